// File: rtl/rr_sched_pkg.sv
// Shared types and defaults for the round-robin scheduler.
// Holds the FSM state encoding, the default sizes and the index-width helper.
package rr_sched_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping.
// pick_id is 0 and pick is all-zero when no request is set.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_id,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sched.sv
// Round-robin scheduler with a hold-time watchdog sharing one resource.
// FSM: IDLE arbitrates, BUSY holds the grant, GAP forces one dead cycle.
module rr_sched
  import rr_sched_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          gnt,
  output logic [idx_w(NREQ)-1:0]   gnt_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);
  localparam logic [HW-1:0] HCNT_MAX = HW'(MAX_HOLD - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IW-1:0]   gnt_id_nxt;
  logic            busy_nxt, timeout_nxt;
  logic            rel, hold_exp;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_id;
  logic            any;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      hcnt    <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      hcnt    <= hcnt_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hcnt_nxt    = hcnt;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    rel         = done[gnt_id] || !req[gnt_id];
    hold_exp    = (hcnt == HCNT_MAX);

    case (state)
      IDLE: begin
        if (any) begin
          gnt_nxt    = pick;
          gnt_id_nxt = pick_id;
          busy_nxt   = 1'b1;
          hcnt_nxt   = '0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (rel || hold_exp) begin
          gnt_nxt     = '0;
          gnt_id_nxt  = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
          // A release in the expiry cycle wins over the watchdog.
          timeout_nxt = !rel;
          state_nxt   = GAP;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      GAP: state_nxt = IDLE;
      default: begin
        state_nxt  = IDLE;
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_sched.sv
// Directed bench for rr_sched and the standalone rr_pick picker.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rr_sched;
  import rr_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  logic [3:0] p_req = '0;
  logic [1:0] p_ptr = '0;
  logic [3:0] p_pick;
  logic [1:0] p_id;
  logic       p_any;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_sched #(.NREQ(4), .MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  rr_pick #(.NREQ(4)) u_pick_tb (
    .req     (p_req),
    .ptr     (p_ptr),
    .pick    (p_pick),
    .pick_id (p_id),
    .any     (p_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] r;
    logic [1:0] p;
    logic [3:0] pk;
    logic [1:0] id;
    logic       an;
  } pvec_t;

  pvec_t pv[8] = '{
    '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0},
    '{4'b1111, 2'd0, 4'b0001, 2'd0, 1'b1},
    '{4'b1111, 2'd3, 4'b1000, 2'd3, 1'b1},
    '{4'b0011, 2'd3, 4'b0001, 2'd0, 1'b1},
    '{4'b0100, 2'd1, 4'b0100, 2'd2, 1'b1},
    '{4'b1010, 2'd2, 4'b1000, 2'd3, 1'b1},
    '{4'b0110, 2'd3, 4'b0010, 2'd1, 1'b1},
    '{4'b1001, 2'd1, 4'b1000, 2'd3, 1'b1}
  };

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int g;

    // Standalone picker vectors.
    for (int i = 0; i < 8; i++) begin
      p_req = pv[i].r;
      p_ptr = pv[i].p;
      #1;
      chk($sformatf("pick[%0d]", i), 32'(p_pick), 32'(pv[i].pk));
      chk($sformatf("pick_id[%0d]", i), 32'(p_id), 32'(pv[i].id));
      chk($sformatf("pick_any[%0d]", i), 32'(p_any), 32'(pv[i].an));
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;

    // Round robin with all requesters active, done after 3 grant cycles.
    req = 4'b1111;
    tick;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      chk($sformatf("rr_gnt[%0d]", k), 32'(gnt), 32'(4'b0001 << g));
      chk($sformatf("rr_id[%0d]", k), 32'(gnt_id), 32'(g));
      chk($sformatf("rr_busy[%0d]", k), 32'(busy), 1);
      tick;
      tick;
      chk($sformatf("rr_hold[%0d]", k), 32'(gnt), 32'(4'b0001 << g));
      done = 4'b0001 << g;
      tick;
      done = '0;
      chk($sformatf("rr_gap1[%0d]", k), 32'(gnt), 0);
      chk($sformatf("rr_gap1_busy[%0d]", k), 32'(busy), 0);
      tick;
      chk($sformatf("rr_gap2[%0d]", k), 32'(gnt), 0);
      tick;
    end
    chk("rr_next", 32'(gnt), 32'(4'b0010));

    // Abandon: grantee 1 drops req without done.
    req = '0;
    tick;
    chk("abn_gnt", 32'(gnt), 0);
    chk("abn_id", 32'(gnt_id), 0);
    chk("abn_timeout", 32'(timeout), 0);
    tick;
    req = 4'b1110;
    tick;
    chk("abn_ptr_gnt", 32'(gnt), 32'(4'b0100));

    // Pointer wrap: ptr=3 after granting 2, only 0 and 1 requesting.
    done = 4'b0100;
    tick;
    done = '0;
    req  = 4'b0011;
    tick;
    tick;
    chk("wrap_gnt0", 32'(gnt), 32'(4'b0001));
    done = 4'b0010;
    tick;
    chk("ng_done_gnt", 32'(gnt), 32'(4'b0001));
    done = 4'b0001;
    tick;
    done = '0;
    tick;
    tick;
    chk("wrap_gnt1", 32'(gnt), 32'(4'b0010));
    chk("wrap_id1", 32'(gnt_id), 1);
    done = 4'b0010;
    req  = '0;
    tick;
    done = '0;
    tick;

    // Watchdog: 16 cycles of grant, then one timeout cycle, then re-grant.
    req = 4'b0010;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wd_gnt[%0d]", i), 32'(gnt), 32'(4'b0010));
      chk($sformatf("wd_to_lo[%0d]", i), 32'(timeout), 0);
      tick;
    end
    chk("wd_gnt_off", 32'(gnt), 0);
    chk("wd_timeout", 32'(timeout), 1);
    tick;
    chk("wd_timeout_end", 32'(timeout), 0);
    chk("wd_idle_gnt", 32'(gnt), 0);
    tick;
    chk("wd_regrant", 32'(gnt), 32'(4'b0010));

    // done in the same cycle as hcnt reaching MAX_HOLD-1.
    repeat (15) tick;
    chk("sim_gnt_held", 32'(gnt), 32'(4'b0010));
    done = 4'b0010;
    tick;
    done = '0;
    chk("sim_gnt_off", 32'(gnt), 0);
    chk("sim_timeout", 32'(timeout), 0);
    tick;
    chk("sim_timeout_later", 32'(timeout), 0);

    // Reset asserted mid-BUSY clears outputs without a clock edge.
    req = 4'b0001;
    tick;
    chk("mid_gnt", 32'(gnt), 32'(4'b0001));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_id", 32'(gnt_id), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_timeout", 32'(timeout), 0);
    req = 4'b0100;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_gnt", 32'(gnt), 32'(4'b0100));
    chk("post_rst_id", 32'(gnt_id), 2);
    chk("post_rst_busy", 32'(busy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
